// File: rtl/snake_pkg.sv
// Shared constants for the snake game blocks: state encoding, score width, timing.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    localparam int SCORE_W        = 8;
    localparam int MAX_SCORE_DEF  = 99;
    localparam int CLK_HZ         = 25_000_000;
    // One second of hold time per displayed value.
    localparam int ALT_PERIOD_DEF = CLK_HZ;

endpackage

// File: rtl/alt_timer.sv
// Free-running modulo-PERIOD counter with synchronous clear and a one-cycle wrap pulse.
module alt_timer #(
    parameter int PERIOD = 4,
    parameter int W      = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    logic [W-1:0] cnt;

    // Wrap is asserted during the last count so the consumer toggles on the same edge the counter returns to 0.
    assign wrap = en && (cnt == W'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/score_keeper.sv
// Game score accumulator with saturating add, high-score retention and post-game score/high alternation.
module score_keeper
    import snake_pkg::*;
#(
    parameter int MAX_SCORE  = MAX_SCORE_DEF,
    parameter int POINTS     = 1,
    parameter int ALT_PERIOD = ALT_PERIOD_DEF,
    parameter int ALT_W      = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               game_start,
    input  logic               food_eaten,
    input  logic               game_over,
    output logic [SCORE_W-1:0] score_out,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic               showing_high,
    output logic [1:0]         state
);

    state_t             st_q, st_n;
    logic [SCORE_W-1:0] score_q, score_n, high_n, out_n, fin;
    logic [SCORE_W:0]   sum9;
    logic               nh_n, sh_n;
    logic               alt_clr, alt_wrap;

    assign state = st_q;

    // Counter runs only while holding in OVER; any other state or a restart pins it at 0.
    assign alt_clr = (st_q != ST_OVER) || game_start;

    alt_timer #(
        .PERIOD (ALT_PERIOD),
        .W      (ALT_W)
    ) u_alt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (alt_clr),
        .en    (st_q == ST_OVER),
        .wrap  (alt_wrap)
    );

    // Nine-bit sum so a large POINTS step near the ceiling cannot wrap before clamping.
    assign sum9 = {1'b0, score_q} + (SCORE_W+1)'(POINTS);

    always_comb begin
        fin = score_q;
        if (food_eaten)
            fin = (sum9 > (SCORE_W+1)'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : sum9[SCORE_W-1:0];
    end

    always_comb begin
        st_n    = st_q;
        score_n = score_q;
        high_n  = high_score;
        nh_n    = new_high;
        sh_n    = showing_high;
        case (st_q)
            ST_IDLE: begin
                if (game_start) begin
                    st_n    = ST_PLAY;
                    score_n = '0;
                    nh_n    = 1'b0;
                end
            end
            ST_PLAY: begin
                if (game_over) begin
                    st_n    = ST_OVER;
                    score_n = fin;
                    sh_n    = 1'b0;
                    if (fin > high_score) begin
                        high_n = fin;
                        nh_n   = 1'b1;
                    end
                end else if (game_start) begin
                    score_n = '0;
                end else begin
                    score_n = fin;
                end
            end
            ST_OVER: begin
                if (game_start) begin
                    st_n    = ST_PLAY;
                    score_n = '0;
                    nh_n    = 1'b0;
                    sh_n    = 1'b0;
                end else if (alt_wrap) begin
                    sh_n = ~showing_high;
                end
            end
            default: begin
                st_n    = ST_IDLE;
                score_n = '0;
                nh_n    = 1'b0;
                sh_n    = 1'b0;
            end
        endcase
        // Selecting from next-state values keeps score_out aligned with showing_high.
        out_n = sh_n ? high_n : score_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q         <= ST_IDLE;
            score_q      <= '0;
            high_score   <= '0;
            new_high     <= 1'b0;
            showing_high <= 1'b0;
            score_out    <= '0;
        end else begin
            st_q         <= st_n;
            score_q      <= score_n;
            high_score   <= high_n;
            new_high     <= nh_n;
            showing_high <= sh_n;
            score_out    <= out_n;
        end
    end

endmodule
